spi_master_multi: RTL

Parametrised SPI master, the next generation of the accelerometer-demo SPI master. It adds a configurable data width, multiple chip selects, all four SPI modes (CPOL/CPHA) and a runtime-programmable clock divider. It sits between FPGA control logic (sensor pollers, register sequencers) and off-chip SPI peripherals. A single request/done handshake moves one MSB-first word of 1..DATA_W bits.

---
 rtl/spi_pkg.sv | 39 +++
 rtl/spi_clk_gen.sv | 36 +++
 rtl/spi_master_multi.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the multi-mode SPI master.
// Holds the FSM state type, default widths and SPI mode encodings.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SHIFT = 3'd2,
        TRAIL = 3'd3,
        GAP   = 3'd4
    } spi_state_t;

    localparam int DATA_W_DEF = 32;
    localparam int NCS_DEF    = 4;
    localparam int DIV_W_DEF  = 16;

    localparam int NB_W_DEF   = $clog2(DATA_W_DEF);
    localparam int CS_W_DEF   = (NCS_DEF > 1) ? $clog2(NCS_DEF) : 1;
    localparam int EDGE_W_DEF = $clog2(2 * DATA_W_DEF) + 1;

    // {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic int nb_width(input int dw);
        return $clog2(dw);
    endfunction

    function automatic int cs_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int edge_width(input int dw);
        return $clog2(2 * dw) + 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI master.
// Emits a one-cycle tick every div+1 cycles after a restart.
module spi_clk_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             restart,
    input  logic             en,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] reload;

    // Down-counter; the reload value is captured at restart only
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt    <= '0;
            reload <= '0;
        end else if (restart) begin
            cnt    <= load_val;
            reload <= load_val;
        end else if (en) begin
            if (cnt == '0) begin
                cnt <= reload;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: variable word width, multiple chip selects,
// all four CPOL/CPHA modes and a runtime half-period divider.
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  NCS    = NCS_DEF,
    parameter int  DIV_W  = DIV_W_DEF,
    localparam int NB_W   = nb_width(DATA_W),
    localparam int CS_W   = cs_width(NCS),
    localparam int EDGE_W = edge_width(DATA_W)
) (
    input  logic              clk_in,
    input  logic              rst,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NCS-1:0]    spi_csn,
    input  logic [DATA_W-1:0] mosi_data,
    output logic [DATA_W-1:0] miso_data,
    input  logic [NB_W-1:0]   nbits,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  div,
    input  logic              request,
    output logic              busy,
    output logic              done
);

    spi_state_t        state;
    logic [1:0]        mode_q;
    logic [NB_W-1:0]   nbits_q;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [EDGE_W-1:0] edge_cnt;
    logic [EDGE_W-1:0] next_edge;
    logic [EDGE_W-1:0] last_edge;
    logic [NCS-1:0]    cs_low;
    logic              accept;
    logic              tick;
    logic              edge_now;
    logic              samp_odd;
    logic              samp;
    logic              drive;

    assign accept    = (state == IDLE) && request;
    assign next_edge = edge_cnt + 1'b1;
    assign last_edge = (EDGE_W'(nbits_q) + EDGE_W'(1)) << 1;

    spi_clk_gen #(
        .DIV_W(DIV_W)
    ) u_clk_gen (
        .clk_in  (clk_in),
        .rst     (rst),
        .restart (accept),
        .en      (state != IDLE),
        .load_val(div),
        .tick    (tick)
    );

    // Decode the requested chip select; out-of-range selects none
    always_comb begin
        cs_low = '1;
        for (int i = 0; i < NCS; i++) begin
            if (CS_W'(i) == cs_sel) begin
                cs_low[i] = 1'b0;
            end
        end
    end

    // Sample parity per mode; trailing-edge modes sample on even edges
    always_comb begin
        samp_odd = 1'b1;
        unique case (mode_q)
            SPI_MODE0, SPI_MODE2: samp_odd = 1'b1;
            SPI_MODE1, SPI_MODE3: samp_odd = 1'b0;
        endcase
    end

    assign edge_now = tick && ((state == LEAD) ||
                      ((state == SHIFT) && (edge_cnt != last_edge)));
    assign samp     = edge_now && (next_edge[0] == samp_odd);
    assign drive    = edge_now && !samp && (next_edge != last_edge);

    // Transfer FSM, SCK generation and the shift registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= IDLE;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
            spi_csn   <= '1;
            miso_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mode_q    <= 2'b00;
            nbits_q   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            edge_cnt  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    spi_sck <= cpol;
                    if (request) begin
                        state    <= LEAD;
                        busy     <= 1'b1;
                        mode_q   <= {cpol, cpha};
                        nbits_q  <= nbits;
                        spi_csn  <= cs_low;
                        rx_sr    <= '0;
                        edge_cnt <= '0;
                        if (!cpha) begin
                            spi_mosi <= mosi_data[nbits];
                            tx_sr    <= mosi_data << 1;
                        end else begin
                            tx_sr    <= mosi_data;
                        end
                    end
                end
                LEAD: begin
                    if (tick) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick && (edge_cnt == last_edge)) begin
                        state <= TRAIL;
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        state    <= GAP;
                        spi_csn  <= '1;
                        spi_mosi <= 1'b0;
                    end
                end
                GAP: begin
                    if (tick) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        miso_data <= rx_sr;
                    end
                end
                default: state <= IDLE;
            endcase
            if (edge_now) begin
                spi_sck  <= ~spi_sck;
                edge_cnt <= next_edge;
            end
            if (samp) begin
                rx_sr <= {rx_sr[DATA_W-2:0], spi_miso};
            end
            if (drive) begin
                spi_mosi <= tx_sr[nbits_q];
                tx_sr    <= tx_sr << 1;
            end
        end
    end

endmodule
